// File: rtl/irq_pending_latch_if.sv
// Bus between the interrupt request-capture stage and its consumer.
// The master side drives the request lines, mask, acknowledge and overflow
// clear. The slave side, the latch, returns the encoder inputs, the raw
// pending register and the overflow flags.
interface irq_pending_latch_if #(
    parameter int N = 8
) ();
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    logic [N-1:0]  irq_in;
    logic [N-1:0]  mask;
    logic          ack;
    logic [IW-1:0] ack_id;
    logic          ovf_clr;
    logic [N-1:0]  I;
    logic          EN;
    logic [N-1:0]  pend;
    logic [N-1:0]  ovf;

    modport master (
        output irq_in, mask, ack, ack_id, ovf_clr,
        input  I, EN, pend, ovf
    );

    modport slave (
        input  irq_in, mask, ack, ack_id, ovf_clr,
        output I, EN, pend, ovf
    );
endinterface

// File: rtl/irq_pending_latch.sv
// irq_pending_latch: request-capture stage in front of an N:log2(N) priority
// encoder. Raw requests pass through a 2-flop synchroniser. Each event
// (a rising edge, or the level when EDGE=0) sets a sticky pending bit. An
// acknowledge of the serviced index clears that bit. Masked pending bits
// drive the encoder I/EN inputs.
// Optional feature: define IRQ_OVERFLOW_EN to build sticky per-line overflow
// flags. These record events that were merged into a bit that was already
// pending. When the macro is not defined, ovf is tied to zero and ovf_clr is
// ignored.
module irq_pending_latch #(
    parameter int N    = 8,
    parameter bit EDGE = 1'b1
) (
    input logic               clk,
    input logic               rst,
    irq_pending_latch_if.slave bus
);
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    logic [N-1:0] s1;
    logic [N-1:0] s2;
    logic [N-1:0] prev;
    logic [N-1:0] pend;
    logic [N-1:0] ev;
    logic [N-1:0] ack_vec;

    // Two-flop synchroniser for the asynchronous requests, plus one history stage for edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1   <= '0;
            s2   <= '0;
            prev <= '0;
        end else begin
            s1   <= bus.irq_in;
            s2   <= s1;
            prev <= s2;
        end
    end

    // Event detection; prev resets low, so a line held high across reset counts as a fresh edge
    always_comb begin
        ev = '0;
        if (EDGE) begin
            ev = s2 & ~prev;
        end else begin
            ev = s2;
        end
    end

    // One-hot decode of the acknowledge; indices at or above N match no line and are dropped
    always_comb begin
        ack_vec = '0;
        for (int i = 0; i < N; i++) begin
            ack_vec[i] = bus.ack && (int'(bus.ack_id) == i);
        end
    end

    // Sticky pending bits: a new event beats a same-cycle acknowledge, so no request is lost
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend <= '0;
        end else begin
            pend <= ev | (pend & ~ack_vec);
        end
    end

`ifdef IRQ_OVERFLOW_EN
    logic [N-1:0] ovf_q;

    // Overflow flags: an event landing on a bit that is still pending and not being acked this cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q <= '0;
        end else begin
            ovf_q <= (bus.ovf_clr ? '0 : ovf_q) | (ev & pend & ~ack_vec);
        end
    end

    assign bus.ovf = ovf_q;
`else
    logic unused_ovf_clr;

    assign unused_ovf_clr = bus.ovf_clr;
    assign bus.ovf        = '0;
`endif

    assign bus.pend = pend;
    assign bus.I    = pend & bus.mask;
    assign bus.EN   = |(pend & bus.mask);
endmodule

// File: tb/tb_irq_pending_latch.sv
// Self-checking bench for irq_pending_latch.
// Two instances share one clock and one reset: index 0 uses edge capture and
// index 1 uses level capture. A behavioural model predicts each instance from
// the raw request history: a line has an event when it was sampled high two
// edges ago (and, in edge mode, low three edges ago). On every falling edge
// the outputs are compared against the model. Directed steps add literal
// expectations that pin the model.
module tb_irq_pending_latch;
    logic clk = 1'b0;
    logic rst = 1'b1;

    int errors = 0;
    int checks = 0;

    irq_pending_latch_if #(.N(8)) bus_e ();
    irq_pending_latch_if #(.N(8)) bus_l ();

    irq_pending_latch #(.N(8), .EDGE(1'b1)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus_e)
    );

    irq_pending_latch #(.N(8), .EDGE(1'b0)) dut_lvl (
        .clk(clk),
        .rst(rst),
        .bus(bus_l)
    );

    always #5 clk = ~clk;

    // Model state and input views, indexed by instance (0 = edge, 1 = level)
    logic [7:0] in_irq [2];
    logic [7:0] in_mask [2];
    logic       in_ack [2];
    logic [2:0] in_ack_id [2];
    logic       in_ovf_clr [2];
    logic [7:0] out_pend [2];
    logic [7:0] out_i [2];
    logic       out_en [2];
    logic [7:0] out_ovf [2];

    logic [7:0] m_hist [2][3];
    logic [7:0] m_pend [2];
    logic [7:0] m_ovf [2];
    logic [7:0] m_ev;
    logic       m_acked;

    assign in_irq[0]     = bus_e.irq_in;
    assign in_irq[1]     = bus_l.irq_in;
    assign in_mask[0]    = bus_e.mask;
    assign in_mask[1]    = bus_l.mask;
    assign in_ack[0]     = bus_e.ack;
    assign in_ack[1]     = bus_l.ack;
    assign in_ack_id[0]  = bus_e.ack_id;
    assign in_ack_id[1]  = bus_l.ack_id;
    assign in_ovf_clr[0] = bus_e.ovf_clr;
    assign in_ovf_clr[1] = bus_l.ovf_clr;
    assign out_pend[0]   = bus_e.pend;
    assign out_pend[1]   = bus_l.pend;
    assign out_i[0]      = bus_e.I;
    assign out_i[1]      = bus_l.I;
    assign out_en[0]     = bus_e.EN;
    assign out_en[1]     = bus_l.EN;
    assign out_ovf[0]    = bus_e.ovf;
    assign out_ovf[1]    = bus_l.ovf;

    // Behavioural model: the event rule is applied to the sampled request history, followed by the pending, ack and overflow rules
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int d = 0; d < 2; d++) begin
                for (int k = 0; k < 3; k++) m_hist[d][k] = 8'h00;
                m_pend[d] = 8'h00;
                m_ovf[d]  = 8'h00;
            end
        end else begin
            for (int d = 0; d < 2; d++) begin
                if (d == 0) m_ev = m_hist[d][1] & ~m_hist[d][2];
                else        m_ev = m_hist[d][1];
`ifdef IRQ_OVERFLOW_EN
                if (in_ovf_clr[d]) m_ovf[d] = 8'h00;
`endif
                for (int i = 0; i < 8; i++) begin
                    m_acked = in_ack[d] && (int'(in_ack_id[d]) == i);
                    if (m_ev[i]) begin
`ifdef IRQ_OVERFLOW_EN
                        if (m_pend[d][i] && !m_acked) m_ovf[d][i] = 1'b1;
`endif
                        m_pend[d][i] = 1'b1;
                    end else if (m_acked) begin
                        m_pend[d][i] = 1'b0;
                    end
                end
                m_hist[d][2] = m_hist[d][1];
                m_hist[d][1] = m_hist[d][0];
                m_hist[d][0] = in_irq[d];
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison of both instances against the model
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            checkOutput($sformatf("model_pend%0d", d), {24'h0, out_pend[d]}, {24'h0, m_pend[d]});
            checkOutput($sformatf("model_I%0d", d),    {24'h0, out_i[d]},    {24'h0, m_pend[d] & in_mask[d]});
            checkOutput($sformatf("model_EN%0d", d),   {31'h0, out_en[d]},   {31'h0, |(m_pend[d] & in_mask[d])});
            checkOutput($sformatf("model_ovf%0d", d),  {24'h0, out_ovf[d]},  {24'h0, m_ovf[d]});
        end
    end

    task automatic applyStimulus(input int cycles);
        for (int c = 0; c < cycles; c++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic ackEdge(input logic [2:0] id);
        bus_e.ack    = 1'b1;
        bus_e.ack_id = id;
        applyStimulus(1);
        bus_e.ack    = 1'b0;
    endtask

    initial begin
        bus_e.irq_in = 8'h00; bus_e.mask = 8'hFF; bus_e.ack = 1'b0; bus_e.ack_id = 3'd0; bus_e.ovf_clr = 1'b0;
        bus_l.irq_in = 8'h00; bus_l.mask = 8'hFF; bus_l.ack = 1'b0; bus_l.ack_id = 3'd0; bus_l.ovf_clr = 1'b0;

        applyStimulus(2);
        rst = 1'b0;
        checkOutput("reset_pend", {24'h0, bus_e.pend}, 32'h0);
        checkOutput("reset_EN", {31'h0, bus_e.EN}, 32'h0);

        // Capture and acknowledge of line 5
        bus_e.irq_in = 8'h20;
        applyStimulus(2);
        checkOutput("cap_not_yet", {24'h0, bus_e.pend}, 32'h0);
        applyStimulus(1);
        checkOutput("cap_pend", {24'h0, bus_e.pend}, 32'h20);
        checkOutput("cap_I", {24'h0, bus_e.I}, 32'h20);
        checkOutput("cap_EN", {31'h0, bus_e.EN}, 32'h1);
        bus_e.irq_in = 8'h00;
        ackEdge(3'd5);
        checkOutput("ack_pend", {24'h0, bus_e.pend}, 32'h0);
        checkOutput("ack_EN", {31'h0, bus_e.EN}, 32'h0);
        applyStimulus(3);

        // Masking: masked bits latch, and unmasking is immediate
        bus_e.mask   = 8'h7F;
        bus_e.irq_in = 8'h84;
        applyStimulus(3);
        checkOutput("mask_pend", {24'h0, bus_e.pend}, 32'h84);
        checkOutput("mask_I", {24'h0, bus_e.I}, 32'h04);
        bus_e.mask = 8'hFF;
        #1;
        checkOutput("unmask_I", {24'h0, bus_e.I}, 32'h84);
        bus_e.irq_in = 8'h00;
        ackEdge(3'd7);
        checkOutput("next_I", {24'h0, bus_e.I}, 32'h04);
        ackEdge(3'd2);
        checkOutput("mask_clear", {24'h0, bus_e.pend}, 32'h0);

        // Simultaneous set and clear on line 3, then an ack of a non-pending bit
        bus_e.irq_in = 8'h08;
        applyStimulus(3);
        bus_e.irq_in = 8'h00;
        applyStimulus(3);
        bus_e.irq_in = 8'h08;
        applyStimulus(2);
        ackEdge(3'd3);
        checkOutput("setwins_pend", {24'h0, bus_e.pend}, 32'h08);
        checkOutput("setwins_ovf", {24'h0, bus_e.ovf}, 32'h0);
        ackEdge(3'd6);
        checkOutput("ack_nonpend", {24'h0, bus_e.pend}, 32'h08);
        ackEdge(3'd3);
        checkOutput("held_edge_ack", {24'h0, bus_e.pend}, 32'h0);
        bus_e.irq_in = 8'h00;
        applyStimulus(3);

        // Overflow: a second edge on line 4 while it is still pending
        bus_e.irq_in = 8'h10;
        applyStimulus(3);
        bus_e.irq_in = 8'h00;
        applyStimulus(3);
        bus_e.irq_in = 8'h10;
        applyStimulus(3);
        bus_e.irq_in = 8'h00;
`ifdef IRQ_OVERFLOW_EN
        checkOutput("ovf_set", {24'h0, bus_e.ovf}, 32'h10);
`else
        checkOutput("ovf_set", {24'h0, bus_e.ovf}, 32'h0);
`endif
        ackEdge(3'd4);
        checkOutput("ovf_ack_pend", {24'h0, bus_e.pend}, 32'h0);
`ifdef IRQ_OVERFLOW_EN
        checkOutput("ovf_persist", {24'h0, bus_e.ovf}, 32'h10);
`else
        checkOutput("ovf_persist", {24'h0, bus_e.ovf}, 32'h0);
`endif
        bus_e.ovf_clr = 1'b1;
        applyStimulus(1);
        bus_e.ovf_clr = 1'b0;
        checkOutput("ovf_clr", {24'h0, bus_e.ovf}, 32'h0);
        applyStimulus(3);

        // Asynchronous reset mid-cycle with pend = A5, then line 1 held across the release
        bus_e.irq_in = 8'hA5;
        applyStimulus(3);
        checkOutput("pre_rst_pend", {24'h0, bus_e.pend}, 32'hA5);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("rst_pend", {24'h0, bus_e.pend}, 32'h0);
        checkOutput("rst_I", {24'h0, bus_e.I}, 32'h0);
        checkOutput("rst_EN", {31'h0, bus_e.EN}, 32'h0);
        bus_e.irq_in = 8'h02;
        applyStimulus(1);
        rst = 1'b0;
        applyStimulus(2);
        checkOutput("held_rst_early", {24'h0, bus_e.pend}, 32'h0);
        applyStimulus(1);
        checkOutput("held_rst_pend", {24'h0, bus_e.pend}, 32'h02);
        ackEdge(3'd1);
        bus_e.irq_in = 8'h00;
        applyStimulus(3);

        // Level mode: a held line cannot be acknowledged away
        bus_l.irq_in = 8'h02;
        applyStimulus(3);
        checkOutput("lvl_pend", {24'h0, bus_l.pend}, 32'h02);
        bus_l.ack    = 1'b1;
        bus_l.ack_id = 3'd1;
        applyStimulus(1);
        bus_l.ack    = 1'b0;
        checkOutput("lvl_ack_held", {24'h0, bus_l.pend}, 32'h02);
        bus_l.irq_in = 8'h00;
        applyStimulus(2);
        bus_l.ack = 1'b1;
        applyStimulus(1);
        bus_l.ack = 1'b0;
        checkOutput("lvl_ack_drop", {24'h0, bus_l.pend}, 32'h0);
        applyStimulus(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
